// File: rtl/pong_audio_pkg.sv
// Shared definitions for the Pong audio path: codec device address, codec
// register map and the state encoding of the codec-side I2C responder.
package pong_audio_pkg;

  // 7-bit bus address of the WM8731 codec with CSB tied low
  localparam logic [6:0] WM8731_ADDR = 7'h1A;

  // Codec register addresses, shared with the configuration initiator
  localparam logic [6:0] R_LEFT_LINE_IN  = 7'h00;
  localparam logic [6:0] R_RIGHT_LINE_IN = 7'h01;
  localparam logic [6:0] R_LEFT_HP_OUT   = 7'h02;
  localparam logic [6:0] R_RIGHT_HP_OUT  = 7'h03;
  localparam logic [6:0] R_ANALOG_PATH   = 7'h04;
  localparam logic [6:0] R_DIGITAL_PATH  = 7'h05;
  localparam logic [6:0] R_POWER_DOWN    = 7'h06;
  localparam logic [6:0] R_DIGITAL_IF    = 7'h07;
  localparam logic [6:0] R_SAMPLING      = 7'h08;
  localparam logic [6:0] R_ACTIVE        = 7'h09;
  localparam logic [6:0] R_RESET         = 7'h0F;

  // Responder FSM state type and its legacy-compatible encodings
  typedef logic [2:0] i2c_rsp_state_t;
  localparam i2c_rsp_state_t ST_IDLE     = 3'd0;
  localparam i2c_rsp_state_t ST_ADDR     = 3'd1;
  localparam i2c_rsp_state_t ST_ADDR_ACK = 3'd2;
  localparam i2c_rsp_state_t ST_BYTE1    = 3'd3;
  localparam i2c_rsp_state_t ST_ACK1     = 3'd4;
  localparam i2c_rsp_state_t ST_BYTE2    = 3'd5;
  localparam i2c_rsp_state_t ST_ACK2     = 3'd6;
  localparam i2c_rsp_state_t ST_IGNORE   = 3'd7;

  // Address byte a write transaction to the given device starts with (R/W = 0)
  function automatic logic [7:0] i2c_write_addr_byte(input logic [6:0] dev);
    return {dev, 1'b0};
  endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// Brings one open-drain bus line into the clk domain and reports its settled
// level plus single-cycle rise/fall flags. Lines idle high, so the chain
// resets to 1 to avoid a phantom edge after reset.
module i2c_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Shift the raw line through the synchronizer and remember the previous settled level
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;

endmodule

// File: rtl/codec_i2c_responder.sv
// Write-only I2C responder standing in for the audio codec control port.
// Accepts START / address / two data bytes / STOP, ACKs frames addressed to
// DEV_ADDR with R/W = 0, and reports each complete register write as a
// one-cycle strobe with the 7-bit register address and 9-bit data.
module codec_i2c_responder
  import pong_audio_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR    = WM8731_ADDR,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       I2C_SCLK,
  inout  wire        I2C_SDAT,
  output logic       reg_wr,
  output logic [6:0] reg_addr,
  output logic [8:0] reg_data,
  output logic       busy,
  output logic       frame_err
);

  logic scl_level, scl_rise, scl_fall;
  logic sda_level, sda_rise, sda_fall;
  logic start_evt, stop_evt;

  i2c_rsp_state_t state_q, state_d;
  logic [7:0]     shift_q, shift_d;
  logic [3:0]     bit_cnt_q, bit_cnt_d;
  logic [7:0]     byte1_q, byte1_d;
  logic           sda_low_q, sda_low_d;
  logic           wr_d, ferr_d;
  logic [6:0]     addr_d;
  logic [8:0]     data_d;
  logic           shifting, aborting;

  i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_scl_sync (
    .clk   (clk),
    .reset (reset),
    .raw   (I2C_SCLK),
    .level (scl_level),
    .rise  (scl_rise),
    .fall  (scl_fall)
  );

  i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sda_sync (
    .clk   (clk),
    .reset (reset),
    .raw   (I2C_SDAT),
    .level (sda_level),
    .rise  (sda_rise),
    .fall  (sda_fall)
  );

  // SDA edges only count as bus conditions while SCL is high; both lines share
  // the same synchronizer depth, so their levels stay aligned.
  assign start_evt = sda_fall & scl_level;
  assign stop_evt  = sda_rise & scl_level;

  // Open-drain output: we only ever pull low, and the flop's async reset frees the line at once
  assign I2C_SDAT = sda_low_q ? 1'b0 : 1'bz;

  // Next-state decode: bus conditions first, then bit shifting on SCL rise and ACK handling on SCL fall
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    byte1_d   = byte1_q;
    sda_low_d = sda_low_q;
    wr_d      = 1'b0;
    ferr_d    = 1'b0;
    addr_d    = reg_addr;
    data_d    = reg_data;
    shifting  = (state_q == ST_ADDR) || (state_q == ST_BYTE1) || (state_q == ST_BYTE2);
    aborting  = (state_q == ST_BYTE1) || (state_q == ST_ACK1) || (state_q == ST_BYTE2);

    if (start_evt) begin
      state_d   = ST_ADDR;
      bit_cnt_d = '0;
      sda_low_d = 1'b0;
      ferr_d    = aborting;
    end else if (stop_evt) begin
      state_d   = ST_IDLE;
      bit_cnt_d = '0;
      sda_low_d = 1'b0;
      ferr_d    = aborting;
    end else begin
      if (scl_rise && shifting && (bit_cnt_q != 4'd8)) begin
        shift_d   = {shift_q[6:0], sda_level};
        bit_cnt_d = bit_cnt_q + 4'd1;
      end
      if (scl_fall) begin
        case (state_q)
          ST_ADDR: begin
            if (bit_cnt_q == 4'd8) begin
              bit_cnt_d = '0;
              if (shift_q == i2c_write_addr_byte(DEV_ADDR)) begin
                sda_low_d = 1'b1;
                state_d   = ST_ADDR_ACK;
              end else begin
                state_d   = ST_IGNORE;
              end
            end
          end
          ST_ADDR_ACK: begin
            sda_low_d = 1'b0;
            state_d   = ST_BYTE1;
          end
          ST_BYTE1: begin
            if (bit_cnt_q == 4'd8) begin
              bit_cnt_d = '0;
              byte1_d   = shift_q;
              sda_low_d = 1'b1;
              state_d   = ST_ACK1;
            end
          end
          ST_ACK1: begin
            sda_low_d = 1'b0;
            state_d   = ST_BYTE2;
          end
          ST_BYTE2: begin
            if (bit_cnt_q == 4'd8) begin
              bit_cnt_d = '0;
              sda_low_d = 1'b1;
              state_d   = ST_ACK2;
            end
          end
          ST_ACK2: begin
            sda_low_d = 1'b0;
            wr_d      = 1'b1;
            addr_d    = byte1_q[7:1];
            data_d    = {byte1_q[0], shift_q};
            state_d   = ST_IGNORE;
          end
          default: begin
          end
        endcase
      end
    end
  end

  // Register FSM state, datapath and outputs; busy tracks the state being entered
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      byte1_q   <= '0;
      sda_low_q <= 1'b0;
      reg_wr    <= 1'b0;
      reg_addr  <= '0;
      reg_data  <= '0;
      busy      <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      byte1_q   <= byte1_d;
      sda_low_q <= sda_low_d;
      reg_wr    <= wr_d;
      reg_addr  <= addr_d;
      reg_data  <= data_d;
      busy      <= (state_d != ST_IDLE);
      frame_err <= ferr_d;
    end
  end

endmodule

// File: tb/tb_codec_i2c_responder.sv
// Bench for codec_i2c_responder: bit-bangs I2C frames from byte lists, derives
// expected ACKs, writes and frame errors from the frame contents, and checks
// register-write strobes through a queue drained by an independent monitor.
module tb_codec_i2c_responder;
  import pong_audio_pkg::*;

  localparam int         SYNC         = 2;
  localparam int         PHASE        = 4;
  localparam logic [7:0] WR_ADDR_BYTE = {WM8731_ADDR, 1'b0};

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       scl = 1'b1;
  logic       sda_drive_low = 1'b0;
  wire        sda;
  logic       reg_wr;
  logic [6:0] reg_addr;
  logic [8:0] reg_data;
  logic       busy;
  logic       frame_err;

  typedef struct packed {
    logic [6:0] addr;
    logic [8:0] data;
  } wr_t;

  wr_t        exp_q[$];
  wr_t        mon_exp;
  logic [7:0] frame_q[$];
  int         checks = 0;
  int         errors = 0;
  int         ferr_seen = 0;
  int         ferr_exp = 0;
  logic [6:0] last_addr = '0;
  logic [8:0] last_data = '0;

  pullup (sda);
  assign sda = sda_drive_low ? 1'b0 : 1'bz;

  always #5 clk = ~clk;

  codec_i2c_responder #(.DEV_ADDR(WM8731_ADDR), .SYNC_STAGES(SYNC)) dut (
    .clk       (clk),
    .reset     (reset),
    .I2C_SCLK  (scl),
    .I2C_SDAT  (sda),
    .reg_wr    (reg_wr),
    .reg_addr  (reg_addr),
    .reg_data  (reg_data),
    .busy      (busy),
    .frame_err (frame_err)
  );

  // Pop one expected write per strobe and count frame error pulses
  always @(negedge clk) begin
    if (reg_wr) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL reg_wr_unexpected actual addr=%h data=%h required no strobe", reg_addr, reg_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if (reg_addr !== mon_exp.addr || reg_data !== mon_exp.data) begin
          errors++;
          $display("[TB] FAIL reg_wr_value actual addr=%h data=%h required addr=%h data=%h",
                   reg_addr, reg_data, mon_exp.addr, mon_exp.data);
        end
      end
    end
    if (frame_err) ferr_seen++;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
    end
  endtask

  task automatic waitClk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic busStart();
    sda_drive_low = 1'b0;
    waitClk(PHASE);
    scl = 1'b1;
    waitClk(PHASE);
    sda_drive_low = 1'b1;
    waitClk(PHASE);
    scl = 1'b0;
    waitClk(PHASE);
  endtask

  task automatic busStop();
    sda_drive_low = 1'b1;
    waitClk(PHASE);
    scl = 1'b1;
    waitClk(PHASE);
    sda_drive_low = 1'b0;
    waitClk(SYNC);
    checkOutput("busy_before_stop_seen", 32'(busy), 1);
    waitClk(1);
    checkOutput("busy_after_stop", 32'(busy), 0);
    waitClk(PHASE);
  endtask

  task automatic sendBits(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      sda_drive_low = ~b[i];
      waitClk(PHASE);
      scl = 1'b1;
      waitClk(PHASE);
      scl = 1'b0;
      waitClk(PHASE);
    end
  endtask

  task automatic ackClock(input bit ack_exp, input bit check_hold, input string name);
    sda_drive_low = 1'b0;
    waitClk(PHASE);
    scl = 1'b1;
    waitClk(PHASE / 2);
    checkOutput(name, 32'(sda), ack_exp ? 0 : 1);
    if (check_hold) begin
      checkOutput("hold_reg_addr", 32'(reg_addr), 32'(last_addr));
      checkOutput("hold_reg_data", 32'(reg_data), 32'(last_data));
    end
    waitClk(PHASE / 2);
    scl = 1'b0;
    waitClk(PHASE);
  endtask

  // Sends START plus frame_q; a frame is addressed when its first byte is the codec write address
  task automatic applyStimulus(input bit end_with_stop);
    int  n;
    bit  addressed;
    bit  ack_exp;
    wr_t w;
    n = frame_q.size();
    busStart();
    checkOutput("busy_after_start", 32'(busy), 1);
    checkOutput("frame_err_count", ferr_seen, ferr_exp);
    addressed = (n > 0) && (frame_q[0] == WR_ADDR_BYTE);
    w = '0;
    for (int i = 0; i < n; i++) begin
      ack_exp = (i == 0) ? addressed : (addressed && i <= 2);
      if (addressed && i == 2) begin
        w.addr = frame_q[1][7:1];
        w.data = {frame_q[1][0], frame_q[2]};
        exp_q.push_back(w);
      end
      sendBits(frame_q[i]);
      ackClock(ack_exp, addressed && i == 2, $sformatf("ack_byte%0d", i));
      if (addressed && i == 2) begin
        last_addr = w.addr;
        last_data = w.data;
      end
    end
    if (addressed && (n == 1 || n == 2)) ferr_exp++;
    if (end_with_stop) begin
      busStop();
      checkOutput("frame_err_count_stop", ferr_seen, ferr_exp);
      checkOutput("reg_addr_held", 32'(reg_addr), 32'(last_addr));
      checkOutput("reg_data_held", 32'(reg_data), 32'(last_data));
      checkOutput("pending_writes", exp_q.size(), 0);
    end
  endtask

  // Reset lands while the codec is pulling SDA low for the first data byte ACK
  task automatic resetDuringAck1();
    busStart();
    sendBits(WR_ADDR_BYTE);
    ackClock(1'b1, 1'b0, "ack_addr_pre_reset");
    sendBits(8'h12);
    sda_drive_low = 1'b0;
    waitClk(PHASE);
    scl = 1'b1;
    waitClk(PHASE / 2);
    checkOutput("ack1_before_reset", 32'(sda), 0);
    #1 reset = 1'b0;
    #1;
    checkOutput("sda_released_by_reset", 32'(sda), 1);
    checkOutput("reg_wr_in_reset", 32'(reg_wr), 0);
    checkOutput("reg_addr_in_reset", 32'(reg_addr), 0);
    checkOutput("reg_data_in_reset", 32'(reg_data), 0);
    checkOutput("busy_in_reset", 32'(busy), 0);
    checkOutput("frame_err_in_reset", 32'(frame_err), 0);
    last_addr = '0;
    last_data = '0;
    waitClk(PHASE);
    scl = 1'b0;
    waitClk(PHASE);
    reset = 1'b1;
    waitClk(PHASE);
    scl = 1'b1;
    waitClk(PHASE);
  endtask

  initial begin
    int         n;
    int         sel;
    logic [7:0] a;

    waitClk(3);
    checkOutput("reset_sda", 32'(sda), 1);
    checkOutput("reset_reg_wr", 32'(reg_wr), 0);
    checkOutput("reset_reg_addr", 32'(reg_addr), 0);
    checkOutput("reset_reg_data", 32'(reg_data), 0);
    checkOutput("reset_busy", 32'(busy), 0);
    checkOutput("reset_frame_err", 32'(frame_err), 0);
    reset = 1'b1;
    waitClk(PHASE);

    frame_q = '{WR_ADDR_BYTE, 8'h1E, 8'h00};
    applyStimulus(1'b1);
    frame_q = '{WR_ADDR_BYTE, 8'h11, 8'h12};
    applyStimulus(1'b1);
    frame_q = '{8'h36, 8'hAA};
    applyStimulus(1'b1);
    frame_q = '{8'h35, 8'h55};
    applyStimulus(1'b1);
    frame_q = '{WR_ADDR_BYTE, 8'h0C};
    applyStimulus(1'b1);
    frame_q = '{WR_ADDR_BYTE, 8'h0C, 8'h9F};
    applyStimulus(1'b1);
    frame_q = '{WR_ADDR_BYTE, 8'h01, 8'h23, 8'h55};
    applyStimulus(1'b0);
    frame_q = '{WR_ADDR_BYTE, 8'h0A, 8'h1F};
    applyStimulus(1'b1);

    resetDuringAck1();
    frame_q = '{WR_ADDR_BYTE, 8'h12, 8'h01};
    applyStimulus(1'b1);

    for (int f = 0; f < 40; f++) begin
      n   = $urandom_range(0, 5);
      sel = $urandom_range(0, 3);
      a   = (sel < 2) ? WR_ADDR_BYTE : ((sel == 2) ? 8'h36 : 8'h35);
      frame_q.delete();
      for (int i = 0; i < n; i++) frame_q.push_back((i == 0) ? a : 8'($urandom));
      applyStimulus((f == 39) ? 1'b1 : 1'($urandom_range(0, 1)));
    end

    waitClk(PHASE);
    checkOutput("final_pending_writes", exp_q.size(), 0);
    checkOutput("final_frame_err_count", ferr_seen, ferr_exp);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
